// File: rtl/dmem_load_align.sv
// Load alignment unit: issues a word-aligned read, then extracts and sign/zero-extends
// the addressed byte, halfword or word for writeback. Stalls the requester while busy.
module dmem_load_align #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [2:0]  width_sign,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [4:0]  rd,
   output logic        dmem_req,
   output logic [31:0] dmem_addr,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_err
);

   // Counter only needs to reach TIMEOUT-1; the expiry cycle itself leaves REQ.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     width_q, width_d;
   logic           sign_q, sign_d;
   logic [1:0]     pos_q, pos_d;
   logic [29:0]    addr_hi_q, addr_hi_d;
   logic [4:0]     wb_rd_q, wb_rd_d;
   logic [31:0]    wb_data_q, wb_data_d;
   logic           wb_err_q, wb_err_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   function automatic logic access_ok(input logic [2:0] ws, input logic [1:0] pos);
      logic ok;
      case (ws)
         3'b001:  ok = (pos == 2'b00);
         3'b010:  ok = (pos[0] == 1'b0);
         3'b100:  ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] ws, input logic sgn,
                                           input logic [1:0] pos, input logic [31:0] d);
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] r;
      h = pos[1] ? d[31:16] : d[15:0];
      case (pos)
         2'b00:   b = d[7:0];
         2'b01:   b = d[15:8];
         2'b10:   b = d[23:16];
         2'b11:   b = d[31:24];
         default: b = 8'h00;
      endcase
      case (ws)
         3'b001:  r = d;
         3'b010:  r = {{16{sgn & h[15]}}, h};
         3'b100:  r = {{24{sgn & b[7]}}, b};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         width_q   <= 3'b000;
         sign_q    <= 1'b0;
         pos_q     <= 2'b00;
         addr_hi_q <= 30'd0;
         wb_rd_q   <= 5'd0;
         wb_data_q <= 32'd0;
         wb_err_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         sign_q    <= sign_d;
         pos_q     <= pos_d;
         addr_hi_q <= addr_hi_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         wb_err_q  <= wb_err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      sign_d    = sign_q;
      pos_d     = pos_q;
      addr_hi_d = addr_hi_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      wb_err_d  = wb_err_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (load_valid) begin
               width_d   = width_sign;
               sign_d    = sign;
               pos_d     = addr[1:0];
               addr_hi_d = addr[31:2];
               wb_rd_d   = rd;
               cnt_d     = '0;
               if (access_ok(width_sign, addr[1:0])) begin
                  state_d = S_REQ;
               end else begin
                  // Rejected loads never touch memory; report the error directly.
                  state_d   = S_RESP;
                  wb_err_d  = 1'b1;
                  wb_data_d = 32'd0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (dmem_ack) begin
               state_d   = S_RESP;
               wb_data_d = extract(width_q, sign_q, pos_q, dmem_rdata);
               wb_err_d  = 1'b0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d   = S_RESP;
               wb_data_d = 32'd0;
               wb_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (wb_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode directly from registered state.
   always_comb begin
      load_ready = (state_q == S_IDLE);
      dmem_req   = (state_q == S_REQ);
      wb_valid   = (state_q == S_RESP);
      dmem_addr  = {addr_hi_q, 2'b00};
      wb_rd      = wb_rd_q;
      wb_data    = wb_data_q;
      wb_err     = wb_err_q;
   end

endmodule

// File: tb/tb_dmem_load_align.sv
// Randomised bench for dmem_load_align: each load is predicted by an arithmetic
// reference model and checked through request, response and backpressure phases.
module tb_dmem_load_align;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic        load_ready;
   logic [2:0]  width_sign;
   logic        sign;
   logic [31:0] addr;
   logic [4:0]  rd;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_load_align #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .width_sign (width_sign),
      .sign       (sign),
      .addr       (addr),
      .rd         (rd),
      .dmem_req   (dmem_req),
      .dmem_addr  (dmem_addr),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .wb_err     (wb_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: load result straight from the addressing rules, using shifts and masks.
   function automatic void model_load(input logic [2:0] ws, input logic sgn, input logic [31:0] a,
                                      input logic [31:0] w, output logic e, output logic [31:0] d);
      int unsigned off;
      logic [31:0] v;
      off = a % 4;
      e = 1'b0;
      v = 32'd0;
      if (ws == 3'b001) begin
         e = (off != 0);
         v = w;
      end else if (ws == 3'b010) begin
         e = (off % 2 != 0);
         v = (w >> (8 * off)) & 32'h0000FFFF;
         if (sgn && v >= 32'h00008000) v = v + 32'hFFFF0000;
      end else if (ws == 3'b100) begin
         v = (w >> (8 * off)) & 32'h000000FF;
         if (sgn && v >= 32'h00000080) v = v + 32'hFFFFFF00;
      end else begin
         e = 1'b1;
      end
      d = e ? 32'd0 : v;
   endfunction

   task automatic run_load(input logic [2:0] ws, input logic sgn, input logic [31:0] a,
                           input logic [4:0] r, input logic [31:0] word,
                           input int ack_dly, input int bp_cycles);
      logic        e;
      logic [31:0] d;
      logic        acked;
      model_load(ws, sgn, a, word, e, d);
      @(negedge clk);
      check("ready_idle", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      width_sign = ws;
      sign       = sgn;
      addr       = a;
      rd         = r;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      addr       = $urandom;
      rd         = 5'($urandom);
      width_sign = 3'($urandom);
      sign       = 1'($urandom);
      if (!e) begin
         acked = 1'b0;
         for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check("req_high", 32'(dmem_req), 32'd1);
            check("req_addr", dmem_addr, a & 32'hFFFFFFFC);
            check("no_wb_in_req", 32'(wb_valid), 32'd0);
            load_valid = 1'($urandom);
            if (k == ack_dly) begin
               dmem_ack   = 1'b1;
               dmem_rdata = word;
            end
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            load_valid = 1'b0;
            if (k == ack_dly) begin
               acked = 1'b1;
               break;
            end
         end
         if (!acked) begin
            e = 1'b1;
            d = 32'd0;
         end
      end
      @(negedge clk);
      check("wb_valid", 32'(wb_valid), 32'd1);
      check("wb_err", 32'(wb_err), 32'(e));
      check("wb_data", wb_data, d);
      check("wb_rd", 32'(wb_rd), 32'(r));
      check("req_low_resp", 32'(dmem_req), 32'd0);
      check("busy_resp", 32'(load_ready), 32'd0);
      for (int c = 0; c < bp_cycles; c++) begin
         wb_ready   = 1'b0;
         load_valid = 1'($urandom);
         dmem_ack   = 1'($urandom);
         dmem_rdata = $urandom;
         @(negedge clk);
         check("hold_valid", 32'(wb_valid), 32'd1);
         check("hold_data", wb_data, d);
         check("hold_rd", 32'(wb_rd), 32'(r));
         check("hold_err", 32'(wb_err), 32'(e));
         check("hold_busy", 32'(load_ready), 32'd0);
         check("hold_noreq", 32'(dmem_req), 32'd0);
      end
      load_valid = 1'b0;
      dmem_ack   = 1'b0;
      wb_ready   = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      check("wb_valid_drop", 32'(wb_valid), 32'd0);
      check("ready_back", 32'(load_ready), 32'd1);
      check("noreq_idle", 32'(dmem_req), 32'd0);
   endtask

   task automatic reset_mid_access();
      @(negedge clk);
      load_valid = 1'b1;
      width_sign = 3'b100;
      sign       = 1'b1;
      addr       = 32'h0000_0407;
      rd         = 5'd9;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_req", 32'(dmem_req), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_wbv", 32'(wb_valid), 32'd0);
      check("rst_ready", 32'(load_ready), 32'd1);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_rd", 32'(wb_rd), 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h8080_8080;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("late_ack_wbv", 32'(wb_valid), 32'd0);
      check("late_ack_ready", 32'(load_ready), 32'd1);
      check("late_ack_data", wb_data, 32'd0);
      check("late_ack_req", 32'(dmem_req), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ws;
      int         pick;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      width_sign = 3'b000;
      sign       = 1'b0;
      addr       = 32'd0;
      rd         = 5'd0;
      dmem_rdata = 32'd0;
      dmem_ack   = 1'b0;
      wb_ready   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", 32'(load_ready), 32'd1);
      check("reset_req", 32'(dmem_req), 32'd0);
      check("reset_addr", dmem_addr, 32'd0);
      check("reset_wbv", 32'(wb_valid), 32'd0);
      check("reset_rd", 32'(wb_rd), 32'd0);
      check("reset_data", wb_data, 32'd0);
      check("reset_err", 32'(wb_err), 32'd0);
      rst_n = 1'b1;

      run_load(3'b100, 1'b1, 32'h0000_0103, 5'd5, 32'h8012_3456, 2, 0);
      run_load(3'b010, 1'b0, 32'h0000_0202, 5'd7, 32'hBEEF_1234, 0, 0);
      run_load(3'b010, 1'b1, 32'h0000_0202, 5'd7, 32'hBEEF_1234, 0, 1);
      run_load(3'b001, 1'b0, 32'h0000_0301, 5'd3, 32'h1111_1111, 0, 0);
      run_load(3'b011, 1'b0, 32'h0000_0300, 5'd4, 32'h2222_2222, 0, 0);
      run_load(3'b001, 1'b1, 32'h0000_0500, 5'd12, 32'hCAFE_F00D, 1, 5);
      run_load(3'b001, 1'b0, 32'h0000_0600, 5'd13, 32'h1234_5678, 99, 0);
      run_load(3'b001, 1'b0, 32'h0000_0604, 5'd14, 32'h8765_4321, TO - 1, 0);

      for (int i = 0; i < 150; i++) begin
         pick = $urandom_range(0, 3);
         case (pick)
            0:       ws = 3'b001;
            1:       ws = 3'b010;
            2:       ws = 3'b100;
            default: ws = 3'($urandom);
         endcase
         run_load(ws, 1'($urandom), $urandom, 5'($urandom), $urandom,
                  $urandom_range(0, TO + 1), $urandom_range(0, 3));
      end

      reset_mid_access();
      run_load(3'b100, 1'b0, 32'h0000_0801, 5'd21, 32'h00AB_CD00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
